// File: rtl/jtopl_timer_ctrl.sv
// Register-side controller for the OPL timer pair: decodes CPU writes to the
// timer registers, returns the status byte and runs the CSM key-on sweep.
module jtopl_timer_ctrl #(
    parameter int CSM_CH = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cenop,
    input  logic       zero,
    input  logic       wr_n,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       flag_A,
    input  logic       flag_B,
    input  logic       irq_n,
    input  logic       overflow_A,
    output logic [7:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       flagen_A,
    output logic       flagen_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       csm_keyon,
    output logic [3:0] csm_ch
);

    typedef enum logic [1:0] {IDLE, ARMED, SWEEP} csm_state_t;

    localparam logic [3:0] LAST_CH = 4'(CSM_CH - 1);

    logic       wr_n_last_reg;
    logic [7:0] addr_reg;
    logic       csm_en_reg;
    logic       csm_en_next;
    logic       wr_accept;
    logic       data_wr;

    csm_state_t state_reg, state_next;
    logic       pend_reg, pend_next;
    logic       keyon_next;
    logic [3:0] ch_next;
    logic       frame;
    logic       ovf_frame;

    // Falling edge of the strobe as seen at cen rate, so a held strobe counts once.
    assign wr_accept = cen && !wr_n && wr_n_last_reg;
    assign data_wr   = wr_accept && addr;
    assign frame     = cenop && zero;
    assign ovf_frame = frame && overflow_A;

    always_comb begin
        csm_en_next = csm_en_reg;
        if (data_wr && addr_reg == 8'h08)
            csm_en_next = din[7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_n_last_reg <= 1'b1;
            addr_reg      <= 8'h00;
            csm_en_reg    <= 1'b0;
            value_A       <= 8'h00;
            value_B       <= 8'h00;
            load_A        <= 1'b0;
            load_B        <= 1'b0;
            flagen_A      <= 1'b1;
            flagen_B      <= 1'b1;
            clr_flag_A    <= 1'b0;
            clr_flag_B    <= 1'b0;
            dout          <= 8'h00;
        end else begin
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            csm_en_reg <= csm_en_next;
            dout       <= {~irq_n, flag_A, flag_B, 5'b0};
            if (cen)
                wr_n_last_reg <= wr_n;
            if (wr_accept && !addr)
                addr_reg <= din;
            if (data_wr) begin
                case (addr_reg)
                    8'h02: value_A <= din;
                    8'h03: value_B <= din;
                    8'h04: begin
                        // Bit 7 is a pure flag reset; the other fields are left alone.
                        if (din[7]) begin
                            clr_flag_A <= 1'b1;
                            clr_flag_B <= 1'b1;
                        end else begin
                            flagen_A <= ~din[6];
                            flagen_B <= ~din[5];
                            load_A   <= din[0];
                            load_B   <= din[1];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pend_reg  <= 1'b0;
            csm_keyon <= 1'b0;
            csm_ch    <= 4'd0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            csm_keyon <= keyon_next;
            csm_ch    <= ch_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pend_next  = pend_reg;
        keyon_next = csm_keyon;
        ch_next    = csm_ch;
        if (!csm_en_next) begin
            state_next = IDLE;
            pend_next  = 1'b0;
            keyon_next = 1'b0;
            ch_next    = 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ovf_frame && load_A)
                        state_next = ARMED;
                end
                ARMED: begin
                    // An overflow arriving here is absorbed into the pending sweep.
                    if (frame) begin
                        state_next = SWEEP;
                        keyon_next = 1'b1;
                        ch_next    = 4'd0;
                    end
                end
                SWEEP: begin
                    if (ovf_frame)
                        pend_next = 1'b1;
                    if (cenop) begin
                        if (csm_ch == LAST_CH) begin
                            keyon_next = 1'b0;
                            ch_next    = 4'd0;
                            pend_next  = 1'b0;
                            state_next = (pend_reg || ovf_frame) ? ARMED : IDLE;
                        end else begin
                            ch_next = csm_ch + 4'd1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule
